instr_encoder: RTL and testbench

- Transmit-side counterpart of the ALU control decoding path. Converts symbolic operation requests into 32-bit LEGv8 instruction words: R-type ADD/SUB/AND/ORR, D-type LDUR/STUR, CB-type CBZ.
- Encoded words are buffered in a small FIFO and delivered over a valid/ready stream.
- Used as instruction-stream generator for processor benches and for instruction-memory preload logic.

---
 rtl/instr_encoder.sv | 129 ++++++++++++
 tb/tb_instr_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: turns symbolic requests into 32-bit words and
// queues them in a small FIFO delivered over a valid/ready stream.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rn,
    input  logic [4:0]      in_rm,
    input  logic [18:0]     in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [CNTW-1:0] count,
    output logic            err,
    output logic [7:0]      err_count
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic            err_q, err_d;
    logic [7:0]      err_count_q, err_count_d;

    logic [31:0] word;
    logic        bad;
    logic        imm_oor;
    logic        accept, push, pop;

    // D-type offsets must fit a signed 9-bit field
    assign imm_oor = (in_imm[18:9] != {10{in_imm[8]}});

    always_comb begin
        word = '0;
        bad  = 1'b0;
        case (in_op)
            3'b000: word = {11'b10001011000, in_rm, 6'b000000, in_rn, in_rd};
            3'b001: word = {11'b11001011000, in_rm, 6'b000000, in_rn, in_rd};
            3'b010: word = {11'b10001010000, in_rm, 6'b000000, in_rn, in_rd};
            3'b011: word = {11'b10101010000, in_rm, 6'b000000, in_rn, in_rd};
            3'b100: begin
                word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
                bad  = imm_oor;
            end
            3'b101: begin
                word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
                bad  = imm_oor;
            end
            3'b110: word = {8'b10110100, in_imm, in_rd};
            default: bad = 1'b1;
        endcase
    end

    assign in_ready  = !reset && (count_q != CNTW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !bad;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_instr_d = out_instr_q;
        err_d       = accept && bad;
        err_count_d = err_count_q;

        if (push) begin
            mem_d[wr_ptr_q] = word;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        // Registered head: keeps the last word visible once the FIFO empties
        if (count_d != '0) begin
            out_instr_d = mem_d[rd_ptr_d];
        end

        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_instr_q <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_instr_q <= out_instr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_instr = out_instr_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rn, in_rm;
    logic [18:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  count;
    logic        err;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    int          m_errcnt = 0;
    bit          m_err = 0;

    instr_encoder #(.DEPTH(DEPTH), .CNTW(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .count(count), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference encoding built from field weights, not bit concatenation
    function automatic void model_enc(input logic [2:0] op, input logic [4:0] rd, rn, rm,
                                      input logic [18:0] imm,
                                      output logic [31:0] w, output bit rej);
        longint v;
        int simm;
        int imm9;
        simm = imm[18] ? int'(imm) - 524288 : int'(imm);
        imm9 = ((simm % 512) + 512) % 512;
        rej  = 0;
        v    = 0;
        case (op)
            3'd0: v = 64'h458 * 2097152 + longint'(rm) * 65536 + longint'(rn) * 32 + longint'(rd);
            3'd1: v = 64'h658 * 2097152 + longint'(rm) * 65536 + longint'(rn) * 32 + longint'(rd);
            3'd2: v = 64'h450 * 2097152 + longint'(rm) * 65536 + longint'(rn) * 32 + longint'(rd);
            3'd3: v = 64'h550 * 2097152 + longint'(rm) * 65536 + longint'(rn) * 32 + longint'(rd);
            3'd4, 3'd5: begin
                v   = (op == 3'd4 ? 64'h7C2 : 64'h7C0) * 2097152 + longint'(imm9) * 4096
                      + longint'(rn) * 32 + longint'(rd);
                rej = (simm < -256) || (simm > 255);
            end
            3'd6: v = 64'd180 * 16777216 + longint'(imm) * 32 + longint'(rd);
            default: rej = 1;
        endcase
        w = v[31:0];
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge,
    // and return at the next negedge ready for sampling.
    task automatic step(input bit v, input logic [2:0] op, input logic [4:0] rd, rn, rm,
                        input logic [18:0] imm, input bit ordy, input bit rst, output bit acc);
        logic [31:0] w;
        bit rej, pop;
        in_valid = v; in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
        out_ready = ordy; reset = rst;
        model_enc(op, rd, rn, rm, imm, w, rej);
        acc = v && !rst && (mq.size() < DEPTH);
        pop = !rst && (mq.size() > 0) && ordy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_err = 0;
            m_errcnt = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            m_err = acc && rej;
            if (m_err && m_errcnt < 255) m_errcnt++;
            if (acc && !rej) mq.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        bit a;
        step(0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0, ordy, 0, a);
    endtask

    task automatic test_reset();
        bit a;
        step(0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0, 0, 1, a);
        step(1, 3'd0, 5'd1, 5'd1, 5'd1, 19'd0, 0, 1, a);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
        checks++; if (err !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL reset_err got=%b/%0d exp=0/0", err, err_count); end
        idle(0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_encodings();
        bit a;
        logic [2:0]  ops[4]  = '{3'd1, 3'd4, 3'd5, 3'd6};
        logic [4:0]  rds[4]  = '{5'd5, 5'd2, 5'd2, 5'd1};
        logic [4:0]  rns[4]  = '{5'd6, 5'd10, 5'd10, 5'd0};
        logic [4:0]  rms[4]  = '{5'd7, 5'd0, 5'd0, 5'd0};
        logic [18:0] imms[4] = '{19'd0, 19'd8, 19'h7FFF8, 19'h7FFFE};
        logic [31:0] exps[4] = '{32'hCB0700C5, 32'hF8408142, 32'hF81F8142, 32'hB4FFFFC1};
        step(1, 3'd0, 5'd3, 5'd1, 5'd2, 19'd0, 1, 0, a);
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h8B020023)
            begin errors++; $display("FAIL enc_add got=%b/%h exp=1/8b020023", out_valid, out_instr); end
        idle(1);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL add_drain_count got=%0d exp=0", count); end
        for (int i = 0; i < 4; i++) begin
            step(1, ops[i], rds[i], rns[i], rms[i], imms[i], 1, 0, a);
            checks++; if (out_valid !== 1'b1 || out_instr !== exps[i])
                begin errors++; $display("FAIL enc_%0d got=%b/%h exp=1/%h", i, out_valid, out_instr, exps[i]); end
            checks++; if (mq.size() == 0 || out_instr !== mq[0])
                begin errors++; $display("FAIL enc_model_%0d got=%h", i, out_instr); end
        end
        idle(1);
    endtask

    task automatic test_reject();
        bit a;
        int base;
        base = m_errcnt;
        step(1, 3'd4, 5'd2, 5'd10, 5'd0, 19'd300, 1, 0, a);
        checks++; if (err !== 1'b1 || err_count !== 8'(base + 1))
            begin errors++; $display("FAIL rej_ldur got=%b/%0d exp=1/%0d", err, err_count, base + 1); end
        step(1, 3'd7, 5'd1, 5'd1, 5'd1, 19'd0, 1, 0, a);
        checks++; if (err !== 1'b1 || err_count !== 8'(base + 2))
            begin errors++; $display("FAIL rej_illegal got=%b/%0d exp=1/%0d", err, err_count, base + 2); end
        checks++; if (count !== 3'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL rej_fifo got=%0d/%b exp=0/0", count, out_valid); end
        idle(1);
        checks++; if (err !== 1'b0 || err_count !== 8'(base + 2))
            begin errors++; $display("FAIL rej_pulse got=%b/%0d exp=0/%0d", err, err_count, base + 2); end
    endtask

    task automatic test_full();
        bit a, done;
        int ndel;
        logic [31:0] ew[5];
        logic [4:0]  rd5[5];
        bit r;
        for (int i = 0; i < 5; i++) begin
            rd5[i] = 5'(i + 10);
            model_enc(3'd3, rd5[i], 5'd4, 5'd9, 19'd0, ew[i], r);
        end
        for (int i = 0; i < 5; i++) step(1, 3'd3, rd5[i], 5'd4, 5'd9, 19'd0, 0, 0, a);
        checks++; if (count !== 3'd4 || in_ready !== 1'b0)
            begin errors++; $display("FAIL full got=%0d/%b exp=4/0", count, in_ready); end
        checks++; if (out_instr !== ew[0]) begin errors++; $display("FAIL full_head got=%h exp=%h", out_instr, ew[0]); end
        done = 0; ndel = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid === 1'b1) begin
                checks++; if (ndel >= 5 || out_instr !== ew[ndel])
                    begin errors++; $display("FAIL drain_%0d got=%h", ndel, out_instr); end
                ndel++;
            end
            step(!done, 3'd3, rd5[4], 5'd4, 5'd9, 19'd0, 1, 0, a);
            if (a) done = 1;
        end
        checks++; if (!done || ndel != 5) begin errors++; $display("FAIL full_total got=%0d exp=5", ndel); end
    endtask

    task automatic test_back_to_back();
        bit a;
        for (int i = 0; i < 2; i++) step(1, 3'd0, 5'(i), 5'd1, 5'd2, 19'd0, 0, 0, a);
        for (int i = 0; i < 6; i++) begin
            step(1, 3'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom), 19'd0, 1, 0, a);
            checks++; if (count !== 3'd2 || mq.size() != 2 || out_instr !== mq[0])
                begin errors++; $display("FAIL b2b_%0d got=%0d/%h", i, count, out_instr); end
        end
        idle(1); idle(1);
    endtask

    task automatic test_reset_mid();
        bit a;
        for (int i = 0; i < 3; i++) step(1, 3'd2, 5'(i), 5'd3, 5'd4, 19'd0, 0, 0, a);
        step(0, 3'd0, 5'd0, 5'd0, 5'd0, 19'd0, 0, 1, a);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || err_count !== 8'd0)
            begin errors++; $display("FAIL midreset got=%0d/%b/%0d exp=0/0/0", count, out_valid, err_count); end
        step(1, 3'd1, 5'd5, 5'd6, 5'd7, 19'd0, 0, 0, a);
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'hCB0700C5 || count !== 3'd1)
            begin errors++; $display("FAIL midreset_enc got=%b/%h exp=1/cb0700c5", out_valid, out_instr); end
        idle(1);
    endtask

    task automatic test_random();
        bit a;
        logic [18:0] imm;
        for (int c = 0; c < 300; c++) begin
            imm = $urandom_range(0, 1) ? 19'($urandom) : 19'($urandom_range(0, 511) - 256);
            step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
                 5'($urandom), imm, $urandom_range(0, 9) < 6, 0, a);
            checks++;
            if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) || err !== m_err ||
                err_count !== 8'(m_errcnt) || in_ready !== (mq.size() < DEPTH) ||
                (mq.size() != 0 && out_instr !== mq[0])) begin
                errors++;
                $display("FAIL rand_%0d got cnt=%0d v=%b w=%h e=%b ec=%0d exp cnt=%0d e=%b ec=%0d w=%h",
                         c, count, out_valid, out_instr, err, err_count, mq.size(), m_err, m_errcnt,
                         (mq.size() != 0) ? mq[0] : 32'h0);
            end
        end
    endtask

    initial begin
        reset = 1; in_valid = 0; in_op = 0; in_rd = 0; in_rn = 0; in_rm = 0; in_imm = 0; out_ready = 0;
        @(negedge clk);
        test_reset();
        test_encodings();
        test_reject();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
